iomem_irq_ctrl: RTL and testbench

//  Interrupt front-end between external IRQ pins and the picorv32 irq_5..irq_7 inputs of vargen.
//  Per-line flow: 2-FF sync, debounce, edge/level detect, sticky pending, mask.

---
 rtl/iomem_irq_ctrl.sv | 130 +++++++++++++
 tb/tb_iomem_irq_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_irq_ctrl.sv
// IRQ front-end for picorv32: per-line sync, debounce, edge/level pending, mask,
// with PENDING/MASK/MODE/STATUS registers on the iomem bus.

module iomem_irq_line #(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DB_CYCLES  = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin,
    input  logic mode,
    input  logic clr,
    output logic deb,
    output logic pending
);
    localparam logic IDLE = ACTIVE_LOW;

    logic [1:0] sync;
    logic [7:0] cnt;
    logic       deb_q;
    logic       s;
    logic       set;

    assign s   = sync[1] ^ IDLE;
    // edge mode looks at the registered deb, so pending trails the deb rise by one cycle
    assign set = mode ? (deb & ~deb_q) : deb;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync    <= {2{IDLE}};
            cnt     <= '0;
            deb     <= 1'b0;
            deb_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync    <= {sync[0], pin};
            deb_q   <= deb;
            pending <= (pending & ~clr) | set;
            if (s == deb) begin
                cnt <= '0;
            end else if (cnt == 8'(DB_CYCLES - 1)) begin
                deb <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

module iomem_irq_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          NUM_IRQ    = 3,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int          DB_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               iomem_valid,
    output logic               iomem_ready,
    input  logic [3:0]         iomem_wstrb,
    input  logic [31:0]        iomem_addr,
    input  logic [31:0]        iomem_wdata,
    output logic [31:0]        iomem_rdata,
    input  logic [NUM_IRQ-1:0] irq_pin,
    output logic [NUM_IRQ-1:0] irq_out
);
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] status;
    logic [NUM_IRQ-1:0] clr;
    logic [31:0]        rd_data;
    logic               match;
    logic               sel;
    logic               we;
    logic               unused_bits;

    assign match = (iomem_addr[31:4] == BASE_ADDR[31:4]);
    // ~iomem_ready keeps a held request from being acknowledged twice in a row
    assign sel   = iomem_valid & match & ~iomem_ready;
    assign we    = sel & iomem_wstrb[0];
    assign clr   = (we && iomem_addr[3:2] == 2'd0) ? iomem_wdata[NUM_IRQ-1:0] : '0;

    assign unused_bits = ^{iomem_addr[1:0], iomem_wstrb[3:1], iomem_wdata[31:NUM_IRQ]};

    iomem_irq_line #(
        .ACTIVE_LOW(ACTIVE_LOW),
        .DB_CYCLES (DB_CYCLES)
    ) u_line [NUM_IRQ-1:0] (
        .clk    (clk),
        .resetn (resetn),
        .pin    (irq_pin),
        .mode   (mode),
        .clr    (clr),
        .deb    (status),
        .pending(pending)
    );

    always_comb begin
        rd_data = '0;
        case (iomem_addr[3:2])
            2'd0:    rd_data[NUM_IRQ-1:0] = pending;
            2'd1:    rd_data[NUM_IRQ-1:0] = mask;
            2'd2:    rd_data[NUM_IRQ-1:0] = mode;
            default: rd_data[NUM_IRQ-1:0] = status;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            mask        <= '0;
            mode        <= '0;
        end else begin
            iomem_ready <= sel;
            iomem_rdata <= sel ? rd_data : 32'd0;
            if (we) begin
                case (iomem_addr[3:2])
                    2'd1:    mask <= iomem_wdata[NUM_IRQ-1:0];
                    2'd2:    mode <= iomem_wdata[NUM_IRQ-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign irq_out = pending & mask;
endmodule

// File: tb/tb_iomem_irq_ctrl.sv
// Scoreboard bench for iomem_irq_ctrl: a window-based reference model predicts
// bus responses and irq_out; a negedge monitor compares against the DUT.

module tb_iomem_irq_ctrl;
    localparam int          N    = 3;
    localparam bit          AL   = 1'b1;
    localparam int          DB   = 4;
    localparam logic [31:0] BASE = 32'h0300_0000;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          iomem_valid = 1'b0;
    logic          iomem_ready;
    logic [3:0]    iomem_wstrb = 4'h0;
    logic [31:0]   iomem_addr = 32'h0;
    logic [31:0]   iomem_wdata = 32'h0;
    logic [31:0]   iomem_rdata;
    logic [N-1:0]  irq_pin = {N{AL}};
    logic [N-1:0]  irq_out;

    always #5 clk = ~clk;

    iomem_irq_ctrl #(
        .BASE_ADDR (BASE),
        .NUM_IRQ   (N),
        .ACTIVE_LOW(AL),
        .DB_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .irq_pin    (irq_pin),
        .irq_out    (irq_out)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int failures = 0;

    // Reference model: a line's debounced level flips to a new value once the
    // synchronised (two-edge delayed) pin has shown that value on DB consecutive
    // edges since the last reset.
    int           cyc = 0;
    int           rst_edge = 0;
    logic [N-1:0] hist [0:255];
    logic [N-1:0] m_pend = '0, m_mask = '0, m_mode = '0, m_deb = '0, m_deb_d = '0;
    bit           m_ready = 1'b0;

    initial for (int i = 0; i < 256; i++) hist[i] = '0;

    always @(posedge clk) begin : model
        logic [N-1:0] set, clr, nd;
        logic [31:0]  rd;
        bit           sel, flip;
        cyc++;
        if (!resetn) begin
            m_pend = '0; m_mask = '0; m_mode = '0; m_deb = '0; m_deb_d = '0;
            m_ready = 1'b0;
            rst_edge = cyc;
            hist[cyc % 256] = '0;
            hist[(cyc - 1) % 256] = '0;
        end else begin
            for (int i = 0; i < N; i++)
                set[i] = m_mode[i] ? (m_deb[i] && !m_deb_d[i]) : m_deb[i];
            clr = '0;
            sel = iomem_valid && (iomem_addr[31:4] == BASE[31:4]) && !m_ready;
            if (sel) begin
                rd = 32'h0;
                case (iomem_addr[3:2])
                    2'd0: rd[N-1:0] = m_pend;
                    2'd1: rd[N-1:0] = m_mask;
                    2'd2: rd[N-1:0] = m_mode;
                    2'd3: rd[N-1:0] = m_deb;
                endcase
                q.push_back('{cyc, rd});
                if (iomem_wstrb[0]) begin
                    case (iomem_addr[3:2])
                        2'd0: clr    = iomem_wdata[N-1:0];
                        2'd1: m_mask = iomem_wdata[N-1:0];
                        2'd2: m_mode = iomem_wdata[N-1:0];
                        default: ;
                    endcase
                end
            end
            m_ready = sel;
            m_pend  = (m_pend & ~clr) | set;
            nd = m_deb;
            for (int i = 0; i < N; i++) begin
                if (cyc - DB + 1 > rst_edge) begin
                    flip = 1'b1;
                    for (int x = cyc - DB + 1; x <= cyc; x++)
                        if (hist[(x - 2) % 256][i] == m_deb[i]) flip = 1'b0;
                    if (flip) nd[i] = ~m_deb[i];
                end
            end
            m_deb_d = m_deb;
            m_deb   = nd;
            hist[cyc % 256] = irq_pin ^ {N{AL}};
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        checks++;
        if (irq_out !== (m_pend & m_mask)) begin
            failures++;
            $display("FAIL irq_out cyc=%0d got=%b exp=%b", cyc, irq_out, m_pend & m_mask);
        end
        if (q.size() > 0 && q[0].cyc < cyc) begin
            checks++; failures++;
            $display("FAIL missing_ready cyc=%0d expected at cyc=%0d", cyc, q[0].cyc);
            void'(q.pop_front());
        end
        if (iomem_ready) begin
            checks++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                failures++;
                $display("FAIL unexpected_ready cyc=%0d got=1 exp=0", cyc);
            end else begin
                e = q.pop_front();
                if (iomem_rdata !== e.data) begin
                    failures++;
                    $display("FAIL rdata cyc=%0d addr=%h got=%h exp=%h", cyc, iomem_addr, iomem_rdata, e.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // hold>0: keep valid for exactly that many edges; hold=0: wait for ready
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input int hold);
        bit got;
        iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
        if (hold > 0) begin
            tick(hold);
        end else begin
            got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                tick(1);
                got = iomem_ready;
            end
            if (!got) begin
                checks++; failures++;
                $display("FAIL bus_timeout addr=%h got=no_ready exp=ready", a);
            end
        end
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        bus(BASE + 32'(off), 4'h1, d, 0);
    endtask

    task automatic rd(input logic [3:0] off);
        bus(BASE + 32'(off), 4'h0, 32'h0, 0);
    endtask

    initial begin
        // T1: reset with pins toggling
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            irq_pin = N'($urandom);
            tick(1);
        end
        irq_pin = {N{AL}};
        resetn = 1'b1;
        tick(DB + 4);
        for (int r = 0; r < 4; r++) rd(4'(r * 4));

        // T2: edge mode on line 0, then W1C
        wr(4'h8, 32'h1);
        wr(4'h4, 32'h7);
        irq_pin[0] = ~AL;
        tick(DB + 4);
        rd(4'h0);
        wr(4'h0, 32'h1);
        rd(4'h0);
        irq_pin[0] = AL;
        tick(DB + 4);

        // T3: glitch one cycle shorter than the window
        irq_pin[1] = ~AL;
        tick(DB - 1);
        irq_pin[1] = AL;
        tick(DB + 4);
        rd(4'hC);
        rd(4'h0);

        // T4: level mode re-sets while asserted, stays clear once released
        wr(4'h8, 32'h0);
        wr(4'h4, 32'h4);
        irq_pin[2] = ~AL;
        tick(DB + 4);
        wr(4'h0, 32'h4);
        rd(4'h0);
        irq_pin[2] = AL;
        tick(DB + 4);
        wr(4'h0, 32'h4);
        rd(4'h0);
        tick(2);
        rd(4'h0);

        // T5: handshake shapes and address miss
        rd(4'hC);
        bus(BASE + 32'hC, 4'h0, 32'h0, 2);
        bus(BASE + 32'hC, 4'h0, 32'h0, 3);
        bus(BASE + 32'h10, 4'h0, 32'h0, 3);
        tick(2);

        // T6: W1C lands on the same edge as a new edge-mode set
        wr(4'h8, 32'h1);
        wr(4'h4, 32'h1);
        wr(4'h0, 32'h7);
        tick(2);
        irq_pin[0] = ~AL;
        tick(2 + DB);
        bus(BASE, 4'h1, 32'h1, 0);
        rd(4'h0);
        irq_pin[0] = AL;
        tick(DB + 4);

        // reset in the middle of a MASK write
        iomem_valid = 1'b1; iomem_addr = BASE + 32'h4; iomem_wstrb = 4'h1; iomem_wdata = 32'h7;
        resetn = 1'b0;
        tick(2);
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        resetn = 1'b1;
        tick(1);
        rd(4'h4);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            int act;
            act = int'($urandom_range(0, 99));
            if (act < 40) begin
                irq_pin[$urandom_range(0, N - 1)] = 1'($urandom);
                tick(int'($urandom_range(1, 2 * DB)));
            end else if (act < 85) begin
                bus(BASE + 32'($urandom_range(0, 3) * 4), 4'($urandom), 32'($urandom), 0);
            end else if (act < 95) begin
                bus(BASE + 32'h10 + 32'($urandom_range(0, 15) * 16), 4'($urandom), 32'($urandom), 2);
            end else begin
                iomem_valid = 1'($urandom);
                iomem_addr = BASE + 32'($urandom_range(0, 3) * 4);
                iomem_wstrb = 4'($urandom);
                iomem_wdata = 32'($urandom);
                resetn = 1'b0;
                tick(int'($urandom_range(1, 2)));
                iomem_valid = 1'b0; iomem_wstrb = 4'h0;
                resetn = 1'b1;
                tick(1);
            end
        end

        tick(DB + 6);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0 outstanding", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
